// File: rtl/rate_pkg.sv
// Shared constants for the display-counter rate enable generator:
// FSM state encoding and default divider settings for a 50 MHz board clock.
package rate_pkg;

  localparam logic [0:0] S_PAUSE = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  localparam int CNT_W_DEF = 28;
  localparam int DIV0_DEF  = 1;
  localparam int DIV1_DEF  = 50_000_000;
  localparam int DIV2_DEF  = 100_000_000;
  localparam int DIV3_DEF  = 200_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous switch and button inputs,
// with a configurable value loaded on asynchronous clear.
module sync_2ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clock,
  input  logic         i_clear_b,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clock or negedge i_clear_b) begin
    if (!i_clear_b) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rate_enable_gen.sv
// Single-cycle enable generator feeding the T input of the display counter:
// selectable divided rate, pause switch and single-step push button.
module rate_enable_gen
  import rate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV0  = DIV0_DEF,
  parameter int DIV1  = DIV1_DEF,
  parameter int DIV2  = DIV2_DEF,
  parameter int DIV3  = DIV3_DEF
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic [1:0]       speed,
  input  logic             run,
  input  logic             step_n,
  output logic             enable_out,
  output logic             running,
  output logic [CNT_W-1:0] count_q
);

  // The reload constants are truncated to CNT_W, so an oversized divider must stop elaboration.
  localparam longint L_LIM = (CNT_W >= 1 && CNT_W <= 62) ? (longint'(1) << CNT_W) : longint'(0);

  if (CNT_W < 1 || CNT_W > 62 ||
      DIV0 < 1 || DIV1 < 1 || DIV2 < 1 || DIV3 < 1 ||
      longint'(DIV0) - 1 >= L_LIM || longint'(DIV1) - 1 >= L_LIM ||
      longint'(DIV2) - 1 >= L_LIM || longint'(DIV3) - 1 >= L_LIM) begin : g_bad_div
    $error("rate_enable_gen: each DIVn must be >= 1 and DIVn-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] L_DIV0_M1 = CNT_W'(DIV0 - 1);
  localparam logic [CNT_W-1:0] L_DIV1_M1 = CNT_W'(DIV1 - 1);
  localparam logic [CNT_W-1:0] L_DIV2_M1 = CNT_W'(DIV2 - 1);
  localparam logic [CNT_W-1:0] L_DIV3_M1 = CNT_W'(DIV3 - 1);

  logic             w_run_s;
  logic [1:0]       w_speed_s;
  logic             w_step_s;
  logic             w_step_press;
  logic [CNT_W-1:0] w_div_m1;

  logic [0:0]       r_state;
  logic             r_reload_pend;
  logic [1:0]       r_speed_q;
  logic             r_step_prev;
  logic [CNT_W-1:0] r_count;
  logic             r_enable;

  sync_2ff #(.W(1), .RST_VAL(1'b0)) u_sync_run (
    .i_clock(clock), .i_clear_b(clear_b), .i_d(run), .o_q(w_run_s)
  );

  sync_2ff #(.W(2), .RST_VAL(2'b00)) u_sync_speed (
    .i_clock(clock), .i_clear_b(clear_b), .i_d(speed), .o_q(w_speed_s)
  );

  // Button idles high, so its synchronizer clears to 1 to avoid a false press after reset.
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_step (
    .i_clock(clock), .i_clear_b(clear_b), .i_d(step_n), .o_q(w_step_s)
  );

  assign w_step_press = r_step_prev & ~w_step_s;

  always_comb begin
    w_div_m1 = L_DIV0_M1;
    case (r_speed_q)
      2'd0: w_div_m1 = L_DIV0_M1;
      2'd1: w_div_m1 = L_DIV1_M1;
      2'd2: w_div_m1 = L_DIV2_M1;
      2'd3: w_div_m1 = L_DIV3_M1;
      default: w_div_m1 = L_DIV0_M1;
    endcase
  end

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      r_state       <= S_PAUSE;
      r_reload_pend <= 1'b1;
      r_speed_q     <= 2'd0;
      r_step_prev   <= 1'b1;
      r_count       <= '0;
      r_enable      <= 1'b0;
    end else begin
      r_state     <= w_run_s ? S_RUN : S_PAUSE;
      r_speed_q   <= w_speed_s;
      r_step_prev <= w_step_s;

      if (r_state == S_RUN) begin
        if (r_reload_pend) begin
          r_count       <= w_div_m1;
          r_reload_pend <= 1'b0;
          r_enable      <= 1'b0;
        end else if (r_count == '0) begin
          r_count  <= w_div_m1;
          r_enable <= 1'b1;
        end else begin
          r_count  <= r_count - CNT_W'(1);
          r_enable <= 1'b0;
        end
      end else begin
        // Paused: the partial interval is kept so resuming continues where it left off.
        r_enable <= w_step_press;
      end

      if (w_speed_s != r_speed_q) begin
        r_reload_pend <= 1'b1;
      end
    end
  end

  assign enable_out = r_enable;
  assign running    = (r_state == S_RUN);
  assign count_q    = r_count;

endmodule

// File: tb/tb_rate_enable_gen.sv
// Bench for rate_enable_gen with small dividers (1/4/8/16) and a 5-bit countdown.
module tb_rate_enable_gen;

  logic       clock = 1'b0;
  logic       clear_b;
  logic [1:0] speed;
  logic       run;
  logic       step_n;
  logic       enable_out;
  logic       running;
  logic [4:0] count_q;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int pulses  = 0;

  int divs [4] = '{1, 4, 8, 16};

  bit       q_run [$];
  bit [1:0] q_spd [$];
  bit       q_stp [$];
  bit       m_step_prev;
  bit [1:0] m_speed_q;
  bit       m_running;
  bit       m_pend;
  int       m_count;
  bit       m_en;

  rate_enable_gen #(
    .CNT_W(5), .DIV0(1), .DIV1(4), .DIV2(8), .DIV3(16)
  ) dut (
    .clock(clock), .clear_b(clear_b), .speed(speed), .run(run), .step_n(step_n),
    .enable_out(enable_out), .running(running), .count_q(count_q)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_run = '{1'b0, 1'b0};
    q_spd = '{2'd0, 2'd0};
    q_stp = '{1'b1, 1'b1};
    m_step_prev = 1'b1;
    m_speed_q   = 2'd0;
    m_running   = 1'b0;
    m_pend      = 1'b1;
    m_count     = 0;
    m_en        = 1'b0;
  endtask

  // Inputs reach the logic two edges after they are sampled; decisions use pre-edge values.
  task automatic model_edge();
    bit rs; bit [1:0] ss; bit sts; bit press; int div;
    if (!clear_b) return;
    rs  = q_run.pop_front(); q_run.push_back(run);
    ss  = q_spd.pop_front(); q_spd.push_back(speed);
    sts = q_stp.pop_front(); q_stp.push_back(step_n);
    press = m_step_prev && !sts;
    div = divs[m_speed_q];
    if (m_running) begin
      if (m_pend) begin
        m_count = div - 1; m_pend = 1'b0; m_en = 1'b0;
      end else if (m_count == 0) begin
        m_count = div - 1; m_en = 1'b1;
      end else begin
        m_count = m_count - 1; m_en = 1'b0;
      end
    end else begin
      m_en = press;
    end
    if (ss != m_speed_q) m_pend = 1'b1;
    m_speed_q   = ss;
    m_running   = rs;
    m_step_prev = sts;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    if (enable_out === 1'b1) pulses++;
    chk("enable_out", 32'(enable_out), 32'(m_en));
    chk("running",    32'(running),    32'(m_running));
    chk("count_q",    32'(count_q),    32'(m_count));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_count(input string tag, input int val, input int limit);
    int k = 0;
    while (!(m_running && !m_pend && m_count == val) && k < limit) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < limit), 32'd1);
  endtask

  initial begin
    clear_b = 1'b0; run = 1'b1; speed = 2'd2; step_n = 1'b1;
    model_reset();
    #3;
    chk("rst_enable",  32'(enable_out), 32'd0);
    chk("rst_running", 32'(running),    32'd0);
    chk("rst_count",   32'(count_q),    32'd0);
    ticks(3);

    // Release reset: running after 3 edges, reload to 7, pulses every 8 cycles.
    clear_b = 1'b1;
    ticks(3);
    chk("run_at_cycle3", 32'(running), 32'd1);
    tick();
    chk("reload_to_7", 32'(count_q), 32'd7);
    ticks(7);
    chk("no_pulse_before_8", 32'(enable_out), 32'd0);
    tick();
    chk("first_pulse", 32'(enable_out), 32'd1);
    ticks(7);
    tick();
    chk("second_pulse", 32'(enable_out), 32'd1);

    // Divide-by-one then switch to divide-by-four.
    speed = 2'd0;
    ticks(10);
    pulses = 0;
    ticks(5);
    chk("div1_every_cycle", 32'(pulses), 32'd5);
    speed = 2'd1;
    ticks(20);

    // Pause holds a partial interval; resume continues it.
    speed = 2'd3;
    wait_count("wait_cnt8", 8, 60);
    run = 1'b0;
    ticks(3);
    chk("pause_count", 32'(count_q), 32'd5);
    chk("pause_state", 32'(running), 32'd0);
    pulses = 0;
    ticks(100);
    chk("pause_no_pulses", 32'(pulses), 32'd0);
    chk("pause_hold", 32'(count_q), 32'd5);
    run = 1'b1;
    ticks(3);
    chk("resume_state", 32'(running), 32'd1);
    ticks(5);
    chk("resume_no_early", 32'(enable_out), 32'd0);
    tick();
    chk("resume_pulse", 32'(enable_out), 32'd1);

    // Single-step while paused: three long presses give three pulses.
    run = 1'b0;
    ticks(5);
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      step_n = 1'b0;
      ticks(50);
      step_n = 1'b1;
      ticks(20);
    end
    chk("step_pulses", 32'(pulses), 32'd3);

    // Step press while running is ignored.
    speed = 2'd1;
    run = 1'b1;
    ticks(8);
    step_n = 1'b0;
    ticks(6);
    step_n = 1'b1;
    ticks(6);

    // Leaving S_RUN on the terminal-count edge still yields one pulse.
    wait_count("wait_cnt2", 2, 20);
    run = 1'b0;
    ticks(3);
    chk("coincide_pulse", 32'(enable_out), 32'd1);
    chk("coincide_state", 32'(running), 32'd0);
    pulses = 0;
    ticks(10);
    chk("coincide_single", 32'(pulses), 32'd0);

    // Asynchronous clear mid-interval.
    speed = 2'd3;
    run = 1'b1;
    wait_count("wait_cnt3", 3, 60);
    #2;
    clear_b = 1'b0;
    model_reset();
    #1;
    chk("async_enable",  32'(enable_out), 32'd0);
    chk("async_running", 32'(running),    32'd0);
    chk("async_count",   32'(count_q),    32'd0);
    ticks(3);
    clear_b = 1'b1;
    pulses = 0;
    ticks(12);
    chk("release_no_pulse", 32'(pulses), 32'd0);

    // Randomized switch and button activity against the reference model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(39, 0) == 0) run = ~run;
      if ($urandom_range(59, 0) == 0) speed = 2'($urandom_range(3, 0));
      if ($urandom_range(9, 0) == 0) step_n = ~step_n;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rate_enable_gen.md
Name: rate_enable_gen

Overview:
- Upstream stage of the 8-bit T-flip-flop display counter: produces the single-cycle enable that drives the counter's T/enable input.
- Runs off the 50 MHz board clock, so the counter advances at a human-visible rate instead of once per key press.
- Rate is selectable by switches. Supports pause and single-step from a push button.

Parameters:
- CNT_W, 28, width of the countdown register; must satisfy 2^CNT_W > max DIVn.
- DIV0, 1, cycles per enable pulse for speed=0 (every cycle).
- DIV1, 50_000_000, cycles per pulse for speed=1 (1 Hz at 50 MHz).
- DIV2, 100_000_000, cycles per pulse for speed=2 (0.5 Hz).
- DIV3, 200_000_000, cycles per pulse for speed=3 (0.25 Hz).
- Constraint: all DIVn >= 1.

Ports:
- clock, input, 1, system clock; all state updates on its rising edge.
- clear_b, input, 1, asynchronous active-low reset.
- speed, input, 2, rate select (switches); asynchronous, synchronized internally.
- run, input, 1, 1 = free-running, 0 = paused (switch); synchronized internally.
- step_n, input, 1, active-low push button; each press gives one pulse while paused; synchronized internally.
- enable_out, output, 1, registered one-cycle enable pulse to the counter.
- running, output, 1, high while the FSM is in S_RUN.
- count_q, output, CNT_W, current countdown value (debug/HEX).

Behaviour:
- Reset (clear_b=0, asynchronous):
  - enable_out=0, running=0, count_q=0.
  - FSM=S_PAUSE, reload_pend=1, speed_q=0.
  - Synchronizer flops: run/speed flops=0, step_n flops=1.
- Synchronization: run, speed and step_n each pass through 2 flops, so there are 2 cycles of latency before any internal effect. In the text below, run_s, speed_s and step_s are the synchronized values.
- Press detect: step_press=1 for exactly one cycle when step_s goes 1->0 (prev=1, cur=0). Holding the button produces no further presses.
- Speed change: speed_q<=speed_s every cycle. If speed_s!=speed_q, reload_pend<=1 in either state; this overrides any clear of reload_pend in the same cycle. DIV is chosen by speed_q.
- FSM states S_PAUSE, S_RUN:
  - S_PAUSE->S_RUN when run_s=1.
  - S_RUN->S_PAUSE when run_s=0.
  - Transition takes one edge. running reflects the registered state.
- S_RUN, per edge, in priority order:
  1. If reload_pend: count<=DIV-1, reload_pend<=0, enable_out<=0.
  2. Else if count==0: enable_out<=1, count<=DIV-1.
  3. Else: count<=count-1, enable_out<=0.
- Resulting timing: steady-state pulse period is exactly DIV cycles. With DIV=1, enable_out stays high every cycle after the reload cycle.
- S_PAUSE:
  - count holds; it is not reloaded, so resume continues the partial interval.
  - enable_out<=step_press; exactly one pulse per press.
  - A pending reload is applied on the first S_RUN cycle.
- step_press in S_RUN is ignored. A terminal count that coincides with a press yields one pulse, never two.
- Leaving S_RUN on the same edge that count==0: the pulse is still issued, because the state register and enable_out are updated from the same pre-edge state.
- enable_out is never high for more than one consecutive cycle, except when DIV=1 in S_RUN.
- Reset mid-interval: immediately returns to the reset values; no pulse is issued on reset release. The first run then reloads before counting.
- Widths: count is unsigned CNT_W. Constants DIVn-1 are truncated to CNT_W, so parameter checks must reject overflow (elaboration-time error).

Decomposition:
- Shared package rate_pkg: FSM state encoding (S_PAUSE=1'b0, S_RUN=1'b1), the default DIV constants, and the CNT_W default.
- One sub-module, sync_2ff (parameterized width and reset value; async active-low clear_b). It is instantiated for run, speed and step_n.
- FSM, press detect and countdown stay in rate_enable_gen.

Test Plan (sim with DIV0=1, DIV1=4, DIV2=8, DIV3=16, CNT_W=5):
- Reset: clear_b=0 with run=1, speed=2 -> enable_out=0, running=0, count_q=0. Release -> running=1 at cycle 3; reload to 7; first pulse 8 cycles after reload, then every 8 cycles.
- speed=0, run=1 -> after sync and reload, enable_out high every cycle. Switch to speed=1 -> within 4 cycles one reload cycle with enable_out=0, then pulses every 4 cycles.
- Pause: speed=3, run=0 when count_q=5 -> count_q holds 5 and no pulses for 100 cycles. run=1 -> next pulse after 6 more S_RUN cycles.
- Step: paused, step_n held low 50 cycles then released, repeated 3 times -> exactly 3 single-cycle pulses. Step press while running -> no extra pulse.
- Edge coincidence: run drops so that S_RUN->S_PAUSE lands on the edge where count_q==0 -> exactly one pulse. Async clear_b mid-interval (count_q=3) -> all outputs 0 within the same cycle, and no pulse on release.
